// File: rtl/fir_output_decimator.sv
// Post-FIR output stage: drops start-up samples, decimates, rounds/saturates Q16.16
// down to OUT_WIDTH and queues kept samples in a small FWFT FIFO with valid/ready out.
module fir_output_decimator #(
    parameter int IN_INT     = 16,
    parameter int IN_FRAC    = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_FRAC   = 15,
    parameter int DECIM      = 4,
    parameter int DISCARD    = 102,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_INT+IN_FRAC-1:0]     in_data,
    input  logic                          in_valid,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          sat_pulse,
    output logic                          drop_pulse,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam int IW  = IN_INT + IN_FRAC;
    localparam int S   = IN_FRAC - OUT_FRAC;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int DCW = (DISCARD > 1) ? $clog2(DISCARD + 1) : 1;
    localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [IW:0] W_HALF = (IW+1)'(1) << (S - 1);

    typedef enum logic {ST_DISCARD, ST_RUN} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_run;
    logic             w_disc_inc;
    logic [DCW-1:0]   r_disc_cnt;
    logic [PW-1:0]    r_phase;
    logic             w_keep;

    // ---------------- start-up discard FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (DISCARD == 0) ? ST_RUN : ST_DISCARD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_DISCARD: if (in_valid && (r_disc_cnt == DCW'(DISCARD - 1))) w_state_next = ST_RUN;
            ST_RUN:     w_state_next = ST_RUN;
            default:    w_state_next = ST_DISCARD;
        endcase
    end

    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_disc_inc = (r_state == ST_DISCARD) && in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disc_cnt <= '0;
        end else if (w_disc_inc) begin
            r_disc_cnt <= r_disc_cnt + DCW'(1);
        end
    end

    // Phase only sees samples that survive the discard window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (w_run && in_valid) begin
            r_phase <= (r_phase == PW'(DECIM - 1)) ? '0 : r_phase + PW'(1);
        end
    end

    assign w_keep = w_run && in_valid && (r_phase == '0);

    // ---------------- round half up, then saturate ----------------
    logic [IW:0]          w_sum;
    logic signed [IW:0]   w_shift;
    logic                 w_fits;
    logic [OUT_WIDTH-1:0] w_conv;

    always_comb begin
        w_sum   = {in_data[IW-1], in_data} + W_HALF;
        w_shift = $signed(w_sum) >>> S;
        w_fits  = (&w_shift[IW:OUT_WIDTH-1]) | ~(|w_shift[IW:OUT_WIDTH-1]);
        if (w_fits) begin
            w_conv = w_shift[OUT_WIDTH-1:0];
        end else if (w_shift[IW]) begin
            w_conv = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            w_conv = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

    logic                 r_stg_valid;
    logic [OUT_WIDTH-1:0] r_stg_data;
    logic                 r_stg_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_valid <= 1'b0;
            r_stg_data  <= '0;
            r_stg_sat   <= 1'b0;
        end else begin
            r_stg_valid <= w_keep;
            r_stg_data  <= w_conv;
            r_stg_sat   <= ~w_fits;
        end
    end

    // ---------------- FWFT output FIFO ----------------
    // Shallow LUT-RAM; the combinational head read is what makes it first-word-fall-through.
    logic [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_level;
    logic                 r_overflow;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    always_comb begin
        w_full = (r_level == (AW+1)'(FIFO_DEPTH));
        w_pop  = out_valid && out_ready;
        w_push = r_stg_valid && (!w_full || w_pop);
        w_drop = r_stg_valid && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= r_stg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop)            r_overflow <= 1'b1;
            else if (clr_overflow) r_overflow <= 1'b0;
        end
    end

    assign out_valid  = (r_level != '0);
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign sat_pulse  = r_stg_valid && r_stg_sat;
    assign drop_pulse = w_drop;
    assign overflow   = r_overflow;

endmodule
